frame_buffer_memory: RTL and testbench
======================================

# frame_buffer_memory

Single-port-write, single-port-read 1-bit-per-pixel memory holding one video frame. It is the storage primitive instantiated twice by `frame_buffer`, which ping-pongs the two copies between drawing and scan-out. Writes and reads are synchronous with one cycle of read latency. After reset, the block sweeps its whole array to 0 before accepting traffic.

## Interface
Clock `clk`; reset `rst` is asynchronous and active-high.

Parameters:
- `SIZE`, default 307200 (640×480): number of 1-bit locations.
- `ADDR_WIDTH`, localparam = `$clog2(SIZE)`: address width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `write_enable`  in  1  write strobe for the current cycle.
- `write_addr`  in  ADDR_WIDTH  pixel index to write.
- `write_data`  in  1  pixel value.
- `read_addr`  in  ADDR_WIDTH  pixel index to read.
- `read_data`  out  1  registered read result.
- `ready`  out  1  high once the post-reset clear sweep is complete.

## Operation
- Storage is SIZE × 1 bit. It must map to block RAM: no reset on the array itself, and no more than one write port.
- Simulation initial contents are all 0. Initial `ready` is 1, so the block is usable without reset, matching how `frame_buffer` instantiates it.
- Clear sweep:
  - Reset assertion clears the sweep counter to 0 and drives `ready` to 0.
  - After deassertion, each rising edge writes 0 to address `counter` and increments the counter.
  - On the edge that writes SIZE-1, `ready` goes to 1 and the counter stops.
- While `ready` = 0:
  - External writes are ignored.
  - `read_data` is forced to 0.
- While `ready` = 1:
  - If `write_enable` = 1 and `write_addr` < SIZE, write `write_data` to `mem[write_addr]`.
  - Writes with `write_addr` ≥ SIZE are dropped silently.
- Read, evaluated every edge using the pre-edge value of `ready`:
  - `read_data` <= `mem[read_addr]` when `ready` = 1 and `read_addr` < SIZE.
  - Otherwise `read_data` <= 0.
- Read-during-write to the same address is read-first: `read_data` returns the old value, and the new value is visible on the following read.

## Timing
- Reset (async): `read_data` = 0 and `ready` = 0 immediately. The counter is 0 and memory contents are otherwise untouched.
- Sweep length is exactly SIZE rising edges after `rst` deasserts. `ready` is observed high after edge number SIZE, counting from 1.
- Reset asserted mid-sweep or mid-operation restarts the sweep from address 0. A write whose edge coincides with reset assertion is not guaranteed.
- Read latency is 1 cycle: `read_addr` presented before edge N gives its data on `read_data` after edge N.
- Write latency is 1 cycle: data written at edge N is readable by a read sampled at edge N+1.
- Write and read ports are independent. A simultaneous write and read at different addresses both complete in the same cycle.
- No handshake. `write_enable` is a single-cycle qualifier with no back-pressure, and read is always active.

## Test plan
Bench uses SIZE=16, ADDR_WIDTH=4.
- Reset and sweep:
  - Pre-load all 16 locations with 1, then pulse `rst`.
  - `read_data` = 0 and `ready` = 0 during reset.
  - `ready` rises after exactly 16 edges.
  - Reads of addresses 0..15 then return 0.
- Write then read: write 1 to addresses 3 and 15 -> `read_data` is 1 one cycle after `read_addr` = 3 or 15, and 0 for address 4.
- Read-during-write: `mem[7]` = 0; write 1 to 7 while reading 7 -> `read_data` = 0 after that edge, and 1 after the next edge.
- Writes during sweep: assert `write_enable` with address 2 and data 1 while `ready` = 0 -> after `ready` rises, address 2 reads 0.
- Reset mid-sweep: assert `rst` after 5 sweep edges and release -> `ready` stays 0 for another full 16 edges.
- Out-of-range (SIZE=12): write 1 to address 13 -> no location changes, and a read of 13 returns 0.

Source files
------------

// File: rtl/frame_buffer_memory.sv
// frame_buffer_memory: SIZE x 1-bit frame store with one write port and one
// registered read port. After reset the array is swept to 0 before external
// traffic is accepted; ready reports the end of that sweep.
module frame_buffer_memory #(
   parameter  int SIZE       = 307200,
   localparam int ADDR_WIDTH = $clog2(SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic                  write_data,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   output logic                  read_data,
   output logic                  ready
);

   localparam logic [ADDR_WIDTH:0]   SIZE_EXT  = (ADDR_WIDTH+1)'(SIZE);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

   // Array carries no reset so it stays a block RAM; the initializer gives
   // the all-zero power-up image in simulation and FPGA bitstreams.
   logic mem [SIZE] = '{default: 1'b0};

   // Power up ready so the block is usable without ever seeing a reset.
   logic                  ready_q     = 1'b1;
   logic                  read_data_q = 1'b0;
   logic [ADDR_WIDTH-1:0] sweep_cnt   = '0;

   logic                  write_in_range;
   logic                  read_in_range;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_wa;
   logic                  mem_wd;

   assign write_in_range = ({1'b0, write_addr} < SIZE_EXT);
   assign read_in_range  = ({1'b0, read_addr}  < SIZE_EXT);

   // Single shared write port: the clear sweep owns it until ready, then the
   // external port takes over. Sweep writes are held off while rst is high so
   // the array is untouched during reset.
   always_comb begin
      mem_we = 1'b0;
      mem_wa = write_addr;
      mem_wd = write_data;
      if (!ready_q) begin
         mem_we = !rst;
         mem_wa = sweep_cnt;
         mem_wd = 1'b0;
      end else if (write_enable && write_in_range) begin
         mem_we = 1'b1;
      end
   end

   // Storage write; the read below samples the old value, giving read-first.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
   end

   // Clear-sweep counter and ready flag; counter parks on the last address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sweep_cnt <= '0;
         ready_q   <= 1'b0;
      end else if (!ready_q) begin
         if (sweep_cnt == LAST_ADDR) begin
            ready_q <= 1'b1;
         end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
         end
      end
   end

   // Registered read, forced to 0 while sweeping or out of range.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         read_data_q <= 1'b0;
      end else if (ready_q && read_in_range) begin
         read_data_q <= mem[read_addr];
      end else begin
         read_data_q <= 1'b0;
      end
   end

   assign read_data = read_data_q;
   assign ready     = ready_q;

endmodule

// File: tb/tb_frame_buffer_memory.sv
module tb_frame_buffer_memory;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // SIZE=16 instance
   logic       rst          = 1'b0;
   logic       write_enable = 1'b0;
   logic [3:0] write_addr   = '0;
   logic       write_data   = 1'b0;
   logic [3:0] read_addr    = '0;
   logic       read_data;
   logic       ready;

   // SIZE=12 instance for out-of-range behaviour
   logic       rst12          = 1'b0;
   logic       write_enable12 = 1'b0;
   logic [3:0] write_addr12   = '0;
   logic       write_data12   = 1'b0;
   logic [3:0] read_addr12    = '0;
   logic       read_data12;
   logic       ready12;

   frame_buffer_memory #(.SIZE(16)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .read_addr    (read_addr),
      .read_data    (read_data),
      .ready        (ready)
   );

   frame_buffer_memory #(.SIZE(12)) u_dut12 (
      .clk          (clk),
      .rst          (rst12),
      .write_enable (write_enable12),
      .write_addr   (write_addr12),
      .write_data   (write_data12),
      .read_addr    (read_addr12),
      .read_data    (read_data12),
      .ready        (ready12)
   );

   int   checks = 0;
   int   errors = 0;
   logic exp_q[$];
   logic model[16];

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag, input logic obs);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed %b expected <empty scoreboard>", tag, obs);
      end else begin
         check(tag, obs, exp_q.pop_front());
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write16(input logic [3:0] a, input logic d);
      write_enable = 1'b1;
      write_addr   = a;
      write_data   = d;
      step();
      write_enable = 1'b0;
      model[a]     = d;
   endtask

   task automatic read16(input logic [3:0] a, input string tag);
      read_addr = a;
      exp_q.push_back(model[a]);
      step();
      pop_check(tag, read_data);
   endtask

   task automatic read12(input logic [3:0] a, input logic exp, input string tag);
      read_addr12 = a;
      exp_q.push_back(exp);
      step();
      pop_check(tag, read_data12);
   endtask

   task automatic write12(input logic [3:0] a, input logic d);
      write_enable12 = 1'b1;
      write_addr12   = a;
      write_data12   = d;
      step();
      write_enable12 = 1'b0;
   endtask

   // Runs a full 16-edge sweep on the SIZE=16 instance, reading rd_a each
   // edge (forced 0) and checking ready only rises after the 16th edge.
   task automatic sweep16(input logic [3:0] rd_a, input string tag);
      read_addr = rd_a;
      for (int n = 1; n <= 16; n++) begin
         exp_q.push_back(1'b0);
         step();
         pop_check({tag, "_rdata"}, read_data);
         check({tag, "_ready"}, ready, (n == 16));
      end
      for (int i = 0; i < 16; i++) model[i] = 1'b0;
   endtask

   task automatic pulse_reset16(input string tag);
      rst = 1'b1;
      #2;
      check({tag, "_ready"}, ready, 1'b0);
      check({tag, "_rdata"}, read_data, 1'b0);
      step();
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) model[i] = 1'b0;
      #1;
      check("init_ready", ready, 1'b1);
      check("init_rdata", read_data, 1'b0);
      check("init_ready12", ready12, 1'b1);

      // Pre-load every location with 1 and spot-check.
      for (int i = 0; i < 16; i++) write16(4'(i), 1'b1);
      read16(4'd9, "preload_rd9");
      read16(4'd0, "preload_rd0");

      // Reset and full sweep.
      pulse_reset16("rst1");
      sweep16(4'd5, "sweep1");
      for (int i = 0; i < 16; i++) read16(4'(i), "swept_rd");

      // Write then read.
      write16(4'd3, 1'b1);
      write16(4'd15, 1'b1);
      read16(4'd3, "wr_rd3");
      read16(4'd15, "wr_rd15");
      read16(4'd4, "wr_rd4");

      // Read-during-write: old value first, new value next cycle.
      write_enable = 1'b1;
      write_addr   = 4'd7;
      write_data   = 1'b1;
      read_addr    = 4'd7;
      exp_q.push_back(model[7]);
      step();
      pop_check("rdw_old", read_data);
      write_enable = 1'b0;
      model[7]     = 1'b1;
      exp_q.push_back(model[7]);
      step();
      pop_check("rdw_new", read_data);

      // Reset mid-sweep, then a full sweep with write attempts to address 2.
      pulse_reset16("rst2");
      read_addr = 4'd3;
      for (int n = 0; n < 5; n++) begin
         exp_q.push_back(1'b0);
         step();
         pop_check("part_sweep_rdata", read_data);
      end
      pulse_reset16("rst_mid");
      write_enable = 1'b1;
      write_addr   = 4'd2;
      write_data   = 1'b1;
      sweep16(4'd3, "sweep2");
      write_enable = 1'b0;
      read16(4'd2, "sweep_wr_ignored");
      read16(4'd3, "sweep2_rd3");
      read16(4'd7, "sweep2_rd7");

      // Out-of-range on the SIZE=12 instance.
      write12(4'd13, 1'b1);
      write12(4'd12, 1'b1);
      read12(4'd13, 1'b0, "oor_rd13");
      read12(4'd12, 1'b0, "oor_rd12");
      for (int i = 0; i < 12; i++) read12(4'(i), 1'b0, "oor_in_range_rd");
      write12(4'd11, 1'b1);
      read12(4'd11, 1'b1, "edge_rd11");
      read12(4'd15, 1'b0, "oor_rd15");

      check("scoreboard_empty", (exp_q.size() == 0), 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
